// File: rtl/stream_capture_pkg.sv
// stream_capture_pkg
//   Shared definitions for the streaming-capture FIFO: register offsets,
//   STATUS/CONTROL bit positions, the control-register struct and a helper
//   that formats the CONTROL readback word.
//   Optional feature macro: STREAM_CAPTURE_IRQ_EN (irq output + CONTROL[4]).
package stream_capture_pkg;

    typedef enum logic [1:0] {
        REG_DATA      = 2'd0,
        REG_STATUS    = 2'd1,
        REG_CONTROL   = 2'd2,
        REG_THRESHOLD = 2'd3
    } reg_addr_e;

    localparam int unsigned STATUS_EMPTY_BIT = 16;
    localparam int unsigned STATUS_FULL_BIT  = 17;
    localparam int unsigned STATUS_OVF_BIT   = 18;

    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_DROP_BIT    = 1;
    localparam int unsigned CTRL_FLUSH_BIT   = 2;
    localparam int unsigned CTRL_CLR_OVF_BIT = 3;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 4;

    typedef struct packed {
        logic irq_enable;
        logic drop_mode;
        logic enable;
    } ctrl_t;

    // Flush and clear-overflow are strobes and always read back as 0.
    function automatic logic [31:0] ctrl_readback(input ctrl_t c);
        logic [31:0] r;
        r                  = '0;
        r[CTRL_ENABLE_BIT] = c.enable;
        r[CTRL_DROP_BIT]   = c.drop_mode;
        r[CTRL_IRQ_EN_BIT] = c.irq_enable;
        return r;
    endfunction

endpackage

// File: rtl/stream_capture_ram.sv
// stream_capture_ram
//   Simple dual-port RAM, DATA_W x DEPTH, one write port and one read port
//   with a registered output (block-RAM style, contents not reset).
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr    read request; rd_data valid the cycle after rd_en
//   rd_data          registered read data
module stream_capture_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_capture_fifo.sv
// stream_capture_fifo
//   Streaming-capture FIFO: ready/valid sink on one side, 4-register
//   memory-mapped slave (read latency 1) on the other.
//   Registers: 0 DATA (pop), 1 STATUS, 2 CONTROL, 3 THRESHOLD.
//   Optional feature macro: STREAM_CAPTURE_IRQ_EN adds the irq port and the
//   CONTROL[4] irq_enable bit.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_data/in_ready    streaming sink
//   avs_address/read/write/writedata/readdata   register slave
//   irq                          level interrupt (STREAM_CAPTURE_IRQ_EN only)
module stream_capture_fifo
    import stream_capture_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata
`ifdef STREAM_CAPTURE_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [15:0]       thr_q, thr_d;
    logic              ovf_q, ovf_d;
    logic              data_rsp_q, data_rsp_d;
    logic [31:0]       reg_rdata_q, reg_rdata_d;

    logic              empty, full;
    logic              accept, push, pop, flush, clr_ovf, ctrl_wr, thr_wr;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_wdata;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    // Uses the registered full flag: a pop this cycle cannot reopen the sink.
    assign in_ready = ctrl_q.enable && (ctrl_q.drop_mode || !full);

    assign unused_wdata = ^{avs_writedata[31:16], avs_writedata[CTRL_IRQ_EN_BIT]};

    always_comb begin
        ctrl_wr = avs_write && (reg_addr_e'(avs_address) == REG_CONTROL);
        thr_wr  = avs_write && (reg_addr_e'(avs_address) == REG_THRESHOLD);
        flush   = ctrl_wr && avs_writedata[CTRL_FLUSH_BIT];
        clr_ovf = ctrl_wr && avs_writedata[CTRL_CLR_OVF_BIT];
        accept  = in_valid && in_ready;
        // Flush wins over a simultaneous push or pop; both are lost.
        push    = accept && !full && !flush;
        pop     = avs_read && (reg_addr_e'(avs_address) == REG_DATA) && !empty && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        thr_d  = thr_q;
        if (ctrl_wr) begin
            ctrl_d.enable     = avs_writedata[CTRL_ENABLE_BIT];
            ctrl_d.drop_mode  = avs_writedata[CTRL_DROP_BIT];
`ifdef STREAM_CAPTURE_IRQ_EN
            ctrl_d.irq_enable = avs_writedata[CTRL_IRQ_EN_BIT];
`else
            ctrl_d.irq_enable = 1'b0;
`endif
        end
        if (thr_wr) begin
            thr_d = avs_writedata[15:0];
        end
        // A drop on full in the same cycle as a clear keeps overflow set.
        ovf_d = (ovf_q && !clr_ovf) || (accept && full);
    end

    // DATA responses come straight from the RAM output register; every other
    // response (including an empty DATA read) is captured here and is 0 when
    // nothing was read.
    always_comb begin
        data_rsp_d  = pop;
        reg_rdata_d = '0;
        if (avs_read) begin
            case (reg_addr_e'(avs_address))
                REG_STATUS: begin
                    reg_rdata_d[15:0]             = 16'(level_q);
                    reg_rdata_d[STATUS_EMPTY_BIT] = empty;
                    reg_rdata_d[STATUS_FULL_BIT]  = full;
                    reg_rdata_d[STATUS_OVF_BIT]   = ovf_q;
                end
                REG_CONTROL:   reg_rdata_d = ctrl_readback(ctrl_q);
                REG_THRESHOLD: reg_rdata_d = {16'h0000, thr_q};
                default:       reg_rdata_d = '0;
            endcase
        end
    end

`ifdef STREAM_CAPTURE_IRQ_EN
    logic irq_q, irq_d;

    // Evaluated on next-state values so irq tracks the level it reports.
    always_comb begin
        irq_d = ctrl_d.irq_enable &&
                ((ctrl_d.enable && (16'(level_d) >= thr_d) && (thr_d != '0)) || ovf_d);
    end

    assign irq = irq_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ctrl_q      <= '0;
            thr_q       <= '0;
            ovf_q       <= 1'b0;
            data_rsp_q  <= 1'b0;
            reg_rdata_q <= '0;
`ifdef STREAM_CAPTURE_IRQ_EN
            irq_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ctrl_q      <= ctrl_d;
            thr_q       <= thr_d;
            ovf_q       <= ovf_d;
            data_rsp_q  <= data_rsp_d;
            reg_rdata_q <= reg_rdata_d;
`ifdef STREAM_CAPTURE_IRQ_EN
            irq_q       <= irq_d;
`endif
        end
    end

    assign avs_readdata = data_rsp_q ? 32'(ram_rdata) : reg_rdata_q;

    stream_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_stream_capture_fifo.sv
// tb_stream_capture_fifo
//   Directed bench for stream_capture_fifo (DATA_W=16, DEPTH=8) with a
//   queue-based reference model checked every cycle, plus literal checks.
//   Build with STREAM_CAPTURE_IRQ_EN to include the irq checks.
`timescale 1ns/1ps
module tb_stream_capture_fifo;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;

    logic              clk           = 1'b0;
    logic              reset_n       = 1'b0;
    logic              in_valid      = 1'b0;
    logic [DATA_W-1:0] in_data       = '0;
    logic              in_ready;
    logic [1:0]        avs_address   = 2'd0;
    logic              avs_read      = 1'b0;
    logic              avs_write     = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
`ifdef STREAM_CAPTURE_IRQ_EN
    logic              irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata)
`ifdef STREAM_CAPTURE_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_q[$];
    bit                m_en     = 0;
    bit                m_drop   = 0;
    bit                m_irq_en = 0;
    bit                m_ovf    = 0;
    bit                m_irq    = 0;
    logic [15:0]       m_thr    = '0;
    logic [31:0]       m_rdata  = '0;

    always @(posedge clk or negedge reset_n) begin
        int unsigned n;
        bit          full_pre, ready, xfer, wr_ctl, fl, clr;
        logic [31:0] rd;
        if (!reset_n) begin
            m_q.delete();
            m_en = 0; m_drop = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
            m_thr = '0; m_rdata = '0;
        end else begin
            n        = m_q.size();
            full_pre = (n == DEPTH);
            ready    = m_en && (m_drop || !full_pre);
            xfer     = in_valid && ready;
            wr_ctl   = avs_write && (avs_address == 2'd2);
            fl       = wr_ctl && avs_writedata[2];
            clr      = wr_ctl && avs_writedata[3];
            rd       = '0;
            if (avs_read) begin
                case (avs_address)
                    2'd0: if (!fl && n > 0) rd = 32'(m_q.pop_front());
                    2'd1: rd = {13'b0, m_ovf, full_pre, (n == 0), 16'(n)};
                    2'd2: rd = {27'b0, m_irq_en, 2'b0, m_drop, m_en};
                    default: rd = {16'b0, m_thr};
                endcase
            end
            if (xfer && !full_pre && !fl) m_q.push_back(in_data);
            if (fl) m_q.delete();
            m_ovf = (m_ovf && !clr) || (xfer && full_pre);
            if (wr_ctl) begin
                m_en   = avs_writedata[0];
                m_drop = avs_writedata[1];
`ifdef STREAM_CAPTURE_IRQ_EN
                m_irq_en = avs_writedata[4];
`endif
            end
            if (avs_write && avs_address == 2'd3) m_thr = avs_writedata[15:0];
            m_rdata = rd;
            m_irq   = m_irq_en && ((m_en && m_q.size() >= m_thr && m_thr != 0) || m_ovf);
        end
    end

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("model_in_ready", 32'(in_ready), 32'(m_en && (m_drop || m_q.size() != DEPTH)));
            check("model_readdata", avs_readdata, m_rdata);
`ifdef STREAM_CAPTURE_IRQ_EN
            check("model_irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    int unsigned       s_sent  = 0;
    int unsigned       s_limit = 0;
    logic [DATA_W-1:0] s_base  = '0;

    // One clock; advances any active stream when a transfer happened.
    task automatic step();
        bit fire;
        fire = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (fire && s_limit > 0) begin
            s_sent++;
            if (s_sent >= s_limit) begin
                in_valid = 1'b0;
                s_limit  = 0;
            end else begin
                in_data = DATA_W'(s_base + s_sent);
            end
        end
    endtask

    task automatic start_stream(input logic [DATA_W-1:0] base, input int unsigned n);
        s_base   = base;
        s_sent   = 0;
        s_limit  = n;
        in_data  = base;
        in_valid = 1'b1;
    endtask

    task automatic run_stream(input string name);
        for (int i = 0; i < 40 && in_valid; i++) step();
        check(name, 32'(in_valid), 32'd0);
        in_valid = 1'b0;
        s_limit  = 0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        start_stream(d, 1);
        run_stream("push_done");
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        step();
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] val);
        avs_address   = addr;
        avs_writedata = val;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        // Reset state
        #1;
        check("reset_readdata", avs_readdata, 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd1, d); check("reset_status", d, 32'h0001_0000);
        rd(2'd2, d); check("reset_control", d, 32'h0);
        rd(2'd3, d); check("reset_threshold", d, 32'h0);

        // Basic push / pop
        wr(2'd2, 32'h1);
        push(16'h11); push(16'h22); push(16'h33);
        rd(2'd1, d); check("basic_status", d, 32'h0000_0003);
        rd(2'd0, d); check("basic_pop0", d, 32'h11);
        rd(2'd0, d); check("basic_pop1", d, 32'h22);
        rd(2'd0, d); check("basic_pop2", d, 32'h33);
        rd(2'd1, d); check("basic_empty", d, 32'h0001_0000);

        // Backpressure: 10 words into depth 8
        start_stream(16'h100, 10);
        repeat (12) step();
        check("bp_accepted", 32'(s_sent), 32'd8);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        rd(2'd1, d); check("bp_status_full", d, 32'h0002_0008);
        for (int i = 0; i < 10; i++) begin
            rd(2'd0, d); check("bp_order", d, 32'h100 + 32'(i));
        end
        check("bp_all_sent", 32'(in_valid), 32'd0);
        s_limit = 0;
        rd(2'd1, d); check("bp_empty", d, 32'h0001_0000);

        // Drop mode
        wr(2'd2, 32'h3);
        start_stream(16'h200, 10);
        for (int i = 0; i < 10; i++) begin
            check("drop_ready", 32'(in_ready), 32'd1);
            step();
        end
        check("drop_done", 32'(in_valid), 32'd0);
        s_limit = 0;
        rd(2'd1, d); check("drop_status_ovf", d, 32'h0006_0008);
        wr(2'd2, 32'hB);
        rd(2'd1, d); check("drop_ovf_cleared", d, 32'h0002_0008);
        for (int i = 0; i < 8; i++) begin
            rd(2'd0, d); check("drop_order", d, 32'h200 + 32'(i));
        end

        // Read while empty
        rd(2'd0, d); check("empty_read", d, 32'h0);
        rd(2'd1, d); check("empty_status", d, 32'h0001_0000);
        push(16'h55);
        rd(2'd0, d); check("after_empty_pop", d, 32'h55);

        // Flush with concurrent transfer; overflow preserved
        start_stream(16'h300, 9);
        run_stream("flush_fill_done");
        rd(2'd0, d); check("flush_pre_pop0", d, 32'h300);
        rd(2'd0, d); check("flush_pre_pop1", d, 32'h301);
        rd(2'd0, d); check("flush_pre_pop2", d, 32'h302);
        rd(2'd1, d); check("flush_pre_status", d, 32'h0004_0005);
        start_stream(16'h3FF, 1);
        wr(2'd2, 32'h7);
        check("flush_xfer_taken", 32'(in_valid), 32'd0);
        s_limit = 0;
        rd(2'd1, d); check("flush_status", d, 32'h0005_0000);
        push(16'h77);
        rd(2'd0, d); check("flush_after_pop", d, 32'h77);
        wr(2'd2, 32'h9);
        rd(2'd1, d); check("flush_clr_ovf", d, 32'h0001_0000);

        // Disable stops pushes; stored data still readable
        push(16'h88);
        wr(2'd2, 32'h0);
        check("disable_ready", 32'(in_ready), 32'd0);
        rd(2'd0, d); check("disable_pop", d, 32'h88);

        // Threshold register and ignored writes
        wr(2'd3, 32'hABCD_1234);
        rd(2'd3, d); check("threshold_rb", d, 32'h1234);
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd1, d); check("ro_write_ignored", d, 32'h0001_0000);
        wr(2'd2, 32'h11);
        rd(2'd2, d);
`ifdef STREAM_CAPTURE_IRQ_EN
        check("control_rb", d, 32'h11);
        wr(2'd3, 32'd4);
        push(16'h1); push(16'h2); push(16'h3);
        check("irq_below", 32'(irq), 32'd0);
        push(16'h4);
        check("irq_at_thr", 32'(irq), 32'd1);
        rd(2'd0, d); check("irq_pop_data", d, 32'h1);
        check("irq_fall", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) begin
            rd(2'd0, d); check("irq_drain", d, 32'h2 + 32'(i));
        end
`else
        check("control_rb", d, 32'h01);
`endif

        // Reset mid-operation
        push(16'hA1); push(16'hA2);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_ready", 32'(in_ready), 32'd0);
        check("midreset_readdata", avs_readdata, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd1, d); check("midreset_status", d, 32'h0001_0000);
        rd(2'd2, d); check("midreset_control", d, 32'h0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
